// File: rtl/reorder_buffer_commit_if.sv
// Handshake bundle between dispatch/execute logic and the reorder buffer,
// including the retirement write port that drives the logical register file.
//   master : dispatch/execute side (drives alloc_* and cmp_*, observes retirement)
//   slave  : reorder buffer (accepts alloc_*/cmp_*, drives alloc_ready/alloc_tag
//            and the registered retirement outputs)
interface reorder_buffer_commit_if #(
    parameter int TAG_W = 4
);
    logic             alloc_valid;
    logic             alloc_reg_write;
    logic [4:0]       alloc_rd;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             cmp_valid;
    logic [TAG_W-1:0] cmp_tag;
    logic [31:0]      cmp_data;
    logic             Reg_write;
    logic [4:0]       logical_address;
    logic [31:0]      write_data;
    logic             commit_valid;

    modport master (
        output alloc_valid, alloc_reg_write, alloc_rd,
        output cmp_valid, cmp_tag, cmp_data,
        input  alloc_ready, alloc_tag,
        input  Reg_write, logical_address, write_data, commit_valid
    );

    modport slave (
        input  alloc_valid, alloc_reg_write, alloc_rd,
        input  cmp_valid, cmp_tag, cmp_data,
        output alloc_ready, alloc_tag,
        output Reg_write, logical_address, write_data, commit_valid
    );
endinterface

// File: rtl/reorder_buffer_commit.sv
// In-order retirement buffer feeding the logical register file write port.
// Dispatch allocates entries at the tail in program order, execution units
// mark entries done by tag in any order, and the head retires (one per cycle)
// once done. Only retired results appear on Reg_write/logical_address/write_data.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   flush  : synchronous squash of every in-flight entry
//   bus    : alloc/complete handshake and registered retirement outputs
//   count  : occupied entries (0..DEPTH)
//   empty  : count == 0
//   full   : count == DEPTH
// DEPTH must be a power of two (>= 4) with TAG_W = log2(DEPTH), so head/tail
// wrap naturally through their own overflow.
module reorder_buffer_commit #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    reorder_buffer_commit_if.slave bus,
    output logic [TAG_W:0]       count,
    output logic                 empty,
    output logic                 full
);
    localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_done;
    logic [DEPTH-1:0] ent_rw;
    logic [4:0]       ent_rd   [DEPTH];
    logic [31:0]      ent_data [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic             do_alloc;
    logic             do_commit;
    logic             do_cmp;

    assign full            = (count == DEPTH_C);
    assign empty           = (count == '0);
    // A same-cycle commit does not open a slot: alloc_ready looks at full only.
    assign bus.alloc_ready = !full;
    assign bus.alloc_tag   = tail;

    assign do_alloc  = bus.alloc_valid && !full;
    assign do_commit = ent_valid[head] && ent_done[head];
    // The tail slot is only valid when the buffer is full, in which case no
    // allocation can happen, so allocation always wins over a completion there.
    assign do_cmp    = bus.cmp_valid && ent_valid[bus.cmp_tag];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (do_cmp) begin
                ent_done[bus.cmp_tag] <= 1'b1;
            end
            if (do_commit) begin
                ent_valid[head] <= 1'b0;
                head            <= head + TAG_W'(1);
            end
            // Head and tail only coincide when empty (no commit) or full
            // (no alloc), so this never collides with the commit clear above.
            if (do_alloc) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + TAG_W'(1);
            end
            case ({do_alloc, do_commit})
                2'b10:   count <= count + (TAG_W+1)'(1);
                2'b01:   count <= count - (TAG_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload fields are qualified by valid/done, so they need no reset.
    always_ff @(posedge clk) begin
        if (do_alloc && !flush) begin
            ent_rw[tail] <= bus.alloc_reg_write;
            ent_rd[tail] <= bus.alloc_rd;
        end
        if (do_cmp && !flush) begin
            ent_data[bus.cmp_tag] <= bus.cmp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.Reg_write       <= 1'b0;
            bus.commit_valid    <= 1'b0;
            bus.logical_address <= '0;
            bus.write_data      <= '0;
        end else if (flush) begin
            bus.Reg_write    <= 1'b0;
            bus.commit_valid <= 1'b0;
        end else if (do_commit) begin
            bus.commit_valid    <= 1'b1;
            bus.logical_address <= ent_rd[head];
            bus.write_data      <= ent_data[head];
            // Register 0 is hardwired, so a retirement to it never writes.
            bus.Reg_write       <= ent_rw[head] && (ent_rd[head] != 5'd0);
        end else begin
            bus.Reg_write    <= 1'b0;
            bus.commit_valid <= 1'b0;
        end
    end
endmodule
